etch_cursor_draw: RTL

//  Etch-a-sketch pen stage, directly downstream of the VRAM clear stage. Consumes that stage's draw_ena.

---
 rtl/etch_cursor_draw.sv | 97 +++++++++
 1 files changed

// File: rtl/etch_cursor_draw.sv
// etch_cursor_draw: etch-a-sketch pen stage stepping a cursor over VRAM and plotting pen_color while the pen is down.
// Define CURSOR_WRAP_EN to make the cursor wrap at the screen edges instead of clamping.
module etch_cursor_draw #(
    parameter int H_RES = 240,
    parameter int V_RES = 320,
    parameter int STEP_CYCLES = 1_000_000,
    localparam int L = H_RES * V_RES,
    localparam int AW = $clog2(L),
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          draw_ena,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          pen_down,
    input  logic [15:0]   pen_color,
    output logic          vram_wr_ena,
    output logic [AW-1:0] vram_wr_addr,
    output logic [15:0]   vram_wr_data,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy
);
    localparam int CW = $clog2(STEP_CYCLES);
    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_STEP, S_WRITE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [AW-1:0] pix_addr, pix_n;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic any, mv_l, mv_r, mv_u, mv_d, moved;
    always_comb begin
        any = btn_up | btn_down | btn_left | btn_right;
        mv_r = btn_right & ~btn_left;
        mv_l = btn_left & ~btn_right;
        mv_d = btn_down & ~btn_up;
        mv_u = btn_up & ~btn_down;
`ifdef CURSOR_WRAP_EN
        nx = mv_r ? (cursor_x == XW'(H_RES-1) ? '0 : cursor_x + XW'(1)) :
             mv_l ? (cursor_x == '0 ? XW'(H_RES-1) : cursor_x - XW'(1)) : cursor_x;
        ny = mv_d ? (cursor_y == YW'(V_RES-1) ? '0 : cursor_y + YW'(1)) :
             mv_u ? (cursor_y == '0 ? YW'(V_RES-1) : cursor_y - YW'(1)) : cursor_y;
`else
        nx = mv_r && cursor_x != XW'(H_RES-1) ? cursor_x + XW'(1) :
             mv_l && cursor_x != '0 ? cursor_x - XW'(1) : cursor_x;
        ny = mv_d && cursor_y != YW'(V_RES-1) ? cursor_y + YW'(1) :
             mv_u && cursor_y != '0 ? cursor_y - YW'(1) : cursor_y;
`endif
        moved = nx != cursor_x || ny != cursor_y;
        pix_n = AW'(ny) * AW'(H_RES) + AW'(nx);
    end
    always_comb begin
        state_n = state;
        if (!draw_ena)
            state_n = S_WAIT;
        else
            case (state)
                S_WAIT:  state_n = pen_down ? S_WRITE : S_IDLE;
                S_IDLE:  state_n = any && cnt == '0 ? S_STEP : S_IDLE;
                S_STEP:  state_n = moved && pen_down ? S_WRITE : S_IDLE;
                default: state_n = S_IDLE;
            endcase
    end
    always_ff @(posedge clk)
        state <= rst ? S_WAIT : state_n;
    // pix_addr always holds the address of the current cursor, so a write never needs a fresh multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x <= XW'(H_RES/2);
            cursor_y <= YW'(V_RES/2);
            pix_addr <= AW'((V_RES/2)*H_RES + H_RES/2);
            vram_wr_ena <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            busy <= 1'b0;
            cnt <= '0;
        end else begin
            vram_wr_ena <= state == S_WRITE && draw_ena;
            busy <= state_n == S_STEP || state_n == S_WRITE;
            cnt <= state == S_IDLE && state_n == S_STEP ? CW'(STEP_CYCLES-1) :
                   !any ? '0 : cnt != '0 ? cnt - CW'(1) : cnt;
            if (state == S_STEP && draw_ena) begin
                cursor_x <= nx;
                cursor_y <= ny;
                pix_addr <= pix_n;
            end
            if (state == S_WRITE && draw_ena) begin
                vram_wr_addr <= pix_addr;
                vram_wr_data <= pen_color;
            end
        end
    end
endmodule
